uart_tx_buf: RTL and testbench

//   Buffered 8N1 UART transmitter: a FIFO feeding a baud-timed serializer.
//   It is the transmit-side counterpart of uart_rx. Producers such as echo logic, status

---
 rtl/uart_tx_buf.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_buf.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// Purpose : buffered 8N1 UART transmitter, a byte FIFO feeding a baud-timed
//           serializer; frames go out LSB first and back-to-back while data is queued.
// Latency : a byte accepted into an empty idle buffer starts its start bit one
//           cycle later; each frame lasts 10*DIV cycles.
// Backpressure: tx_ready drops while the FIFO holds FIFO_DEPTH bytes; the producer
//           holds tx_data/tx_valid until accepted. A pop at full does not free a
//           slot for a push in that same cycle.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   tx_data/valid   byte in, valid/ready handshake with tx_ready
//   fifo_level      bytes queued, excluding the byte being shifted
//   tx_busy         frame in progress or bytes queued
//   uart_txd        registered serial line, idle high
module uart_tx_buf #(
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 50,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_busy,
  output logic                          uart_txd
);

  localparam int DIV = (CLK_FREQ * 1_000_000) / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;

  state_t        state_q;
  logic [CW-1:0] baud_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          txd_q;

  logic push;
  logic pop;
  logic bit_end;

  assign bit_end    = (baud_cnt_q == CNT_LAST);
  assign tx_ready   = (level_q != LVL_FULL);
  assign fifo_level = level_q;
  assign tx_busy    = (state_q != S_IDLE) || (level_q != '0);
  assign uart_txd   = txd_q;

  // The serializer takes the head byte either from idle or at the last cycle of
  // a stop bit, which is what lets frames run back-to-back with no idle gap.
  always_comb begin
    push     = tx_valid && tx_ready;
    pop      = (level_q != '0) &&
               ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (pop && !push) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  // Storage carries no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q    <= mem_q[rd_ptr_q];
            baud_cnt_q <= '0;
            txd_q      <= 1'b0;
            state_q    <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            txd_q      <= shift_q[0];
            state_q    <= S_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + CW'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= S_STOP;
            end else begin
              // shift_q[1] becomes the new LSB, so drive it straight away.
              shift_q   <= shift_q >> 1;
              txd_q     <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CW'(1);
          end
        end

        S_STOP: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              txd_q   <= 1'b0;
              state_q <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CW'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
`timescale 1ns/1ps
module tb_uart_tx_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [4:0] fifo_level;
  logic       tx_busy;
  logic       uart_txd;

  logic [7:0] d_tx_data;
  logic       d_tx_valid;
  logic       d_tx_ready;
  logic [4:0] d_fifo_level;
  logic       d_tx_busy;
  logic       d_uart_txd;

  always #5 clk = ~clk;

  // DIV = 1e6 / 1e5 = 10
  uart_tx_buf #(.BAUD_RATE(100000), .CLK_FREQ(1), .FIFO_DEPTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .fifo_level(fifo_level), .tx_busy(tx_busy),
    .uart_txd(uart_txd)
  );

  // Default parameters: DIV = 50e6 / 115200 = 434
  uart_tx_buf u_dflt (
    .clk(clk), .rst_n(rst_n), .tx_data(d_tx_data), .tx_valid(d_tx_valid),
    .tx_ready(d_tx_ready), .fifo_level(d_fifo_level), .tx_busy(d_tx_busy),
    .uart_txd(d_uart_txd)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // line[j] = j-th mid-bit sample (start, d0..d7, stop)
  } vec_t;

  vec_t vecs [5];

  int n_cmp = 0;
  int n_bad = 0;
  int peak_lvl = 0;
  int rdy_bad = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Running check that tx_ready mirrors (level != 16), plus peak level.
  always @(negedge clk) begin
    if (tx_ready !== (fifo_level != 5'd16)) rdy_bad++;
    if (int'(fifo_level) > peak_lvl) peak_lvl = int'(fifo_level);
  end

  // Push count bytes first, first+1, ... holding tx_valid until each is accepted.
  task automatic push_bytes(input logic [7:0] first, input int count);
    for (int i = 0; i < count; i++) begin
      int w;
      w = 0;
      tx_data  = first + 8'(i);
      tx_valid = 1'b1;
      while (!tx_ready && w < 2000) begin
        tick(1);
        w++;
      end
      if (w >= 2000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL push_timeout: byte %0d not accepted in 2000 cycles", i);
        tx_valid = 1'b0;
        return;
      end
      exp_q.push_back(tx_data);
      tick(1);
    end
    tx_valid = 1'b0;
  endtask

  // Decode n frames that must follow each other with no idle gap.
  task automatic rx_frames(input int n, input string tag);
    int w;
    logic [7:0] b;
    logic [7:0] e;
    w = 0;
    while (uart_txd !== 1'b0 && w < 300) begin
      tick(1);
      w++;
    end
    chk({tag, "_first_start"}, uart_txd, 1'b0);
    if (uart_txd !== 1'b0) return;
    for (int f = 0; f < n; f++) begin
      if (f > 0) chk($sformatf("%s_gapless_f%0d", tag, f), uart_txd, 1'b0);
      tick(5);
      for (int j = 0; j < 8; j++) begin
        tick(10);
        b[j] = uart_txd;
      end
      tick(10);
      chk($sformatf("%s_stop_f%0d", tag, f), uart_txd, 1'b1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_extra_f%0d: got 0x%0h, want no frame", tag, f, b);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s_byte_f%0d", tag, f), b, e);
      end
      tick(5);
    end
    chk({tag, "_idle_after"}, uart_txd, 1'b1);
    chk({tag, "_busy_after"}, tx_busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, prev, lows, len, total;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};
    vecs[4] = '{8'h81, 10'b1100000010};

    // 1. Reset, with a write attempt held during reset.
    rst_n = 1'b0; tx_valid = 1'b1; tx_data = 8'hEE;
    d_tx_valid = 1'b0; d_tx_data = 8'h00;
    tick(3);
    chk("rst_write_ignored", fifo_level, 5'd0);
    rst_n = 1'b1; tx_valid = 1'b0;
    tick(1);
    chk("rst_txd", uart_txd, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_level", fifo_level, 5'd0);
    chk("rst_busy", tx_busy, 1'b0);

    // 2. Single-byte frames from the vector table.
    for (int v = 0; v < 5; v++) begin
      tx_data = vecs[v].data; tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      chk($sformatf("v%0d_level_push", v), fifo_level, 5'd1);
      chk($sformatf("v%0d_txd_prefall", v), uart_txd, 1'b1);
      tick(1);
      chk($sformatf("v%0d_txd_fall", v), uart_txd, 1'b0);
      chk($sformatf("v%0d_level_pop", v), fifo_level, 5'd0);
      tick(5);
      for (int j = 0; j < 10; j++) begin
        chk($sformatf("v%0d_bit%0d", v, j), uart_txd, vecs[v].line[j]);
        if (j < 9) tick(10);
      end
      tick(4);
      chk($sformatf("v%0d_busy_last", v), tx_busy, 1'b1);
      tick(1);
      chk($sformatf("v%0d_busy_fall", v), tx_busy, 1'b0);
      chk($sformatf("v%0d_txd_idle", v), uart_txd, 1'b1);
    end

    // 3. Stream 20 bytes with tx_valid held high.
    exp_q.delete(); peak_lvl = 0; rdy_bad = 0;
    fork
      push_bytes(8'h00, 20);
      rx_frames(20, "t3");
    join
    chk("t3_peak_level", peak_lvl, 16);
    chk("t3_ready_vs_level", rdy_bad, 0);

    // 4. Push against a full FIFO exactly when the stop bit pops.
    exp_q.delete();
    fork
      begin
        push_bytes(8'h40, 17);
        chk("t4_full_level", fifo_level, 5'd16);
        chk("t4_full_ready", tx_ready, 1'b0);
        tx_data = 8'h51; tx_valid = 1'b1;
        w = 0; prev = int'(fifo_level);
        while (!tx_ready && w < 300) begin
          prev = int'(fifo_level);
          tick(1);
          w++;
        end
        chk("t4_wait_cycles", w, 85);
        chk("t4_level_before_pop", prev, 16);
        chk("t4_level_after_pop", fifo_level, 5'd15);
        chk("t4_next_start", uart_txd, 1'b0);
        exp_q.push_back(8'h51);
        tick(1);
        tx_valid = 1'b0;
        chk("t4_level_refill", fifo_level, 5'd16);
      end
      rx_frames(18, "t4");
    join

    // 5. Reset pulse 35 cycles into the first of three queued frames.
    tx_data = 8'h00; tx_valid = 1'b1;
    tick(3);
    tx_valid = 1'b0;
    tick(34);
    chk("t5_pre_txd", uart_txd, 1'b0);
    chk("t5_pre_level", fifo_level, 5'd2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("t5_txd", uart_txd, 1'b1);
    chk("t5_level", fifo_level, 5'd0);
    chk("t5_busy", tx_busy, 1'b0);
    chk("t5_ready", tx_ready, 1'b1);
    lows = 0;
    repeat (300) begin
      tick(1);
      if (uart_txd !== 1'b1) lows++;
    end
    chk("t5_no_frames", lows, 0);

    // 6. Default parameters, 0x55: every bit boundary toggles the line.
    d_tx_data = 8'h55; d_tx_valid = 1'b1;
    tick(1);
    d_tx_valid = 1'b0;
    w = 0;
    while (d_uart_txd !== 1'b0 && w < 10) begin
      tick(1);
      w++;
    end
    chk("t6_fall_delay", w, 1);
    total = 0;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("t6_run%0d_val", k), d_uart_txd, (k % 2 == 1) ? 1'b1 : 1'b0);
      prev = int'(d_uart_txd);
      len = 0;
      while (int'(d_uart_txd) == prev && len < 1000) begin
        tick(1);
        len++;
      end
      chk($sformatf("t6_run%0d_len", k), len, 434);
      total += len;
    end
    chk("t6_stop_val", d_uart_txd, 1'b1);
    len = 0;
    while (d_tx_busy !== 1'b0 && len < 1000) begin
      tick(1);
      len++;
    end
    chk("t6_stop_len", len, 434);
    total += len;
    chk("t6_frame_len", total, 4340);
    chk("t6_txd_idle", d_uart_txd, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
